pio_seg_scan: RTL and testbench
===============================

Name: pio_seg_scan

Overview:
- Parametrised successor to the single 8-bit seven-segment output PIO.
- Avalon-MM slave holding NUM_DIGITS segment-pattern registers plus a control register.
- Drives a time-multiplexed, common-anode, active-low display through one shared segment bus and one-hot active-low digit selects.
- Includes a per-slot anti-ghosting dead time.
- Sits on the system interconnect beside the other PIO slaves; the CPU writes patterns and the block scans autonomously.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- ADDR_W, 4, slave address width. 2**ADDR_W must be >= NUM_DIGITS+1.
- SCAN_DIV, 50000, clk cycles per digit slot (>= 2).
- DEAD_CYCLES, 1, blanked cycles at the start of each slot (0..SCAN_DIV-1).
- SEG_RESET, 8'hFF, reset value of every digit register (all segments off, active-low).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, active-low.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- seg_out  out  8  segment drive, active-low, {dp,g,f,e,d,c,b,a}.
- dig_sel  out  NUM_DIGITS  digit enables, active-low one-hot.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n; all registers clear on the falling edge of reset_n regardless of clk.
- Register map:
  - addr 0..NUM_DIGITS-1: DIGn[7:0] segment pattern.
  - addr 2**ADDR_W-1: CTRL. Bit0 EN, bits[8+:NUM_DIGITS] BLANK mask.
  - All other addresses read 0; writes to them are ignored.
- Write: chipselect && !write_n.
  - DIGn <= writedata[7:0].
  - CTRL <= {writedata[8+:NUM_DIGITS], writedata[0]}.
  - Unused writedata bits are ignored.
- Read: readdata is zero-extended from the selected register; unused bits read 0.
- Reset values:
  - DIGn = SEG_RESET; CTRL.EN = 1; BLANK = 0.
  - Slot counter = 0; digit index = 0.
  - seg_out = 8'hFF; dig_sel = all ones.
- Scan engine:
  - Slot counter counts 0..SCAN_DIV-1 while EN = 1.
  - At terminal count the counter returns to 0 and the index advances; index NUM_DIGITS-1 wraps to 0.
- Output registers, updated every cycle:
  - Dead phase: if counter < DEAD_CYCLES, seg_out = 8'hFF and dig_sel = all ones.
  - Digit blanked: if BLANK[index] = 1, seg_out = 8'hFF and dig_sel = all ones for the whole slot; the index still advances.
  - Otherwise: seg_out = DIG[index] and dig_sel = ~(1 << index).
  - Outputs lag the counter/index by exactly one clk.
- Write to the active digit: a write to DIG[index] during its lit phase appears on seg_out on the second clk edge after the write cycle (register update, then output register).
- EN cleared:
  - Counter and index reset to 0 on the next clk.
  - Outputs go off one clk later.
  - Registers remain readable and writable.
- EN set from 0: scanning restarts at digit 0, counter 0, and the dead phase is applied first.
- Simultaneous write to CTRL and terminal count: the new CTRL takes effect from the next cycle. The index advance on that edge still occurs unless the new EN = 0.
- NUM_DIGITS = 1: index is constantly 0; dig_sel = 0 outside the dead phase.
- Reset asserted mid-slot: all state returns to reset values immediately (asynchronously).

Optional Feature:
- Macro: PIO_SEG_SCAN_HEX_DECODE_EN.
- Defined: a DIGn write with writedata[8] = 1 stores the active-low hex glyph of writedata[3:0] instead of writedata[7:0]; DIGn[7] (dp) is taken from writedata[7]. Glyph examples: 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E. Reads return the stored decoded pattern.
- Undefined: writedata[8] is ignored and writedata[7:0] is stored raw.

Test Plan:
- Reset (bench params NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1):
  - Stimulus: release reset_n, then read addr 0..3 and 15.
  - Required: DIG reads 0xFF, CTRL reads 0x1; seg_out = 0xFF throughout the first dead cycle.
- Scan order:
  - Stimulus: write DIG0..3 = 0xC0, 0xF9, 0xA4, 0xB0.
  - Required: dig_sel sequence E, D, B, 7, repeating. Each slot is 1 cycle off (F/FF) then 3 cycles with the matching seg_out. Wrap from digit 3 to digit 0.
- Blank mask:
  - Stimulus: write CTRL = 0x0000_0401 (BLANK[2] = 1).
  - Required: during slot 2, dig_sel = F and seg_out = FF for all 4 cycles; slots 0, 1 and 3 are unchanged.
- Disable and re-enable:
  - Stimulus: write CTRL = 0 mid-slot 2, wait 10 cycles, write CTRL = 1.
  - Required: outputs off 2 clks after the disabling write; after re-enable, digit 0 is the first lit digit following one dead cycle.
- Live update and async reset:
  - Stimulus: write DIG1 = 0x92 while digit 1 is lit.
  - Required: seg_out = 0x92 two edges later.
  - Stimulus: assert reset_n low between edges.
  - Required: seg_out = FF and dig_sel = F immediately, without waiting for a clk edge.
- Hex decode (macro defined):
  - Stimulus: write DIG0 = 0x0000_0108.
  - Required: DIG0 reads 0x00.
  - Stimulus: write DIG0 = 0x0000_018F.
  - Required: DIG0 reads 0x8E.
  - Macro undefined: the same 0x108 write reads back 0x08.

Source files
------------

// File: rtl/pio_seg_scan.sv
// Avalon-MM seven-segment scanner: NUM_DIGITS pattern registers, CTRL (EN, BLANK), multiplexed active-low drive.
// Optional PIO_SEG_SCAN_HEX_DECODE_EN: DIGn writes with writedata[8]=1 store the hex glyph of writedata[3:0].
module pio_seg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter logic [7:0]  SEG_RESET   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  DEAD_END  = CNT_W'(DEAD_CYCLES);

  logic [7:0]            dig_q [NUM_DIGITS];
  logic [7:0]            dig_d [NUM_DIGITS];
  logic                  en_q, en_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  run_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            dig_wval;
  logic                  wr, wr_ctrl;
  logic                  unused_wdata;

  assign wr           = chipselect && !write_n;
  assign wr_ctrl      = wr && (address == CTRL_ADDR);
  assign unused_wdata = ^writedata[31:8+NUM_DIGITS];

`ifdef PIO_SEG_SCAN_HEX_DECODE_EN
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction
  assign dig_wval = writedata[8] ? {writedata[7], hex_glyph(writedata[3:0])} : writedata[7:0];
`else
  assign dig_wval = writedata[7:0];
`endif

  always_comb begin
    dig_d   = dig_q;
    en_d    = en_q;
    blank_d = blank_q;
    if (wr_ctrl) begin
      en_d    = writedata[0];
      blank_d = writedata[8+:NUM_DIGITS];
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (wr && (address == ADDR_W'(i))) dig_d[i] = dig_wval;
    end
  end

  // A CTRL write clearing EN on the terminal count holds the index; otherwise the slot advances.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (!(wr_ctrl && !writedata[0])) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // run_q tracks whether cnt_q/idx_q came from an enabled cycle, so a disable blanks one clk after the reset.
  always_comb begin
    seg_d = '1;
    sel_d = '1;
    if (run_q && (cnt_q >= DEAD_END) && !blank_q[idx_q]) begin
      seg_d = dig_q[idx_q];
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_q[i] <= SEG_RESET;
      en_q    <= 1'b1;
      blank_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      run_q   <= 1'b1;
      seg_q   <= '1;
      sel_q   <= '1;
    end else begin
      dig_q   <= dig_d;
      en_q    <= en_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      run_q   <= en_q;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (address == CTRL_ADDR) begin
      readdata[0]            = en_q;
      readdata[8+:NUM_DIGITS] = blank_q;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(i)) readdata[7:0] = dig_q[i];
      end
    end
  end

  assign seg_out = seg_q;
  assign dig_sel = sel_q;

endmodule

// File: tb/tb_pio_seg_scan.sv
// Self-checking bench for pio_seg_scan (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1) against a timeline model.
module tb_pio_seg_scan;
  localparam int ND = 4;
  localparam int AW = 4;
  localparam int SD = 4;
  localparam int DC = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [7:0]    seg_out;
  logic [ND-1:0] dig_sel;

  int total = 0;
  int bad = 0;

  pio_seg_scan #(.NUM_DIGITS(ND), .ADDR_W(AW), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .SEG_RESET(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_out(seg_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  // Model: m_t counts enabled cycles; slot = m_t/SD mod ND, phase = m_t mod SD.
  logic [7:0]    m_dig [ND];
  logic          m_en;
  logic [ND-1:0] m_blank;
  int            m_t;
  logic          m_run;
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_sel;

  function automatic int slot_of(input int t); return (t / SD) % ND; endfunction
  function automatic int phase_of(input int t); return t % SD; endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  function automatic logic [7:0] stored(input logic [31:0] w);
`ifdef PIO_SEG_SCAN_HEX_DECODE_EN
    if (w[8]) return {w[7], glyph(w[3:0])};
`endif
    return w[7:0];
  endfunction

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
    logic [31:0] r = '0;
    if (a == 4'hF) begin
      r[0] = m_en;
      r[11:8] = m_blank;
    end else if (a < ND) r[7:0] = m_dig[a];
    return r;
  endfunction

  function automatic logic lit_now(input int t, input logic run, input logic [ND-1:0] blk);
    return run && (phase_of(t) >= DC) && !blk[slot_of(t)];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ND; i++) m_dig[i] <= 8'hFF;
      m_en <= 1'b1; m_blank <= '0; m_t <= 0; m_run <= 1'b1;
      exp_seg <= 8'hFF; exp_sel <= '1;
    end else begin
      exp_seg <= lit_now(m_t, m_run, m_blank) ? m_dig[slot_of(m_t)] : 8'hFF;
      exp_sel <= lit_now(m_t, m_run, m_blank) ? ~(ND'(1) << slot_of(m_t)) : '1;
      if (!m_en) m_t <= 0;
      else if (phase_of(m_t) == SD - 1 && chipselect && !write_n && address == 4'hF && !writedata[0])
        m_t <= m_t - (SD - 1);
      else m_t <= m_t + 1;
      m_run <= m_en;
      if (chipselect && !write_n) begin
        if (address == 4'hF) begin
          m_en <= writedata[0];
          m_blank <= writedata[11:8];
        end else if (address < ND) m_dig[address] <= stored(writedata);
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic wait_slot(input int s, input int p);
    int n = 0;
    while (!(slot_of(m_t) == s && phase_of(m_t) == p && m_en) && n < 200) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL wait_slot: no slot %0d phase %0d within %0d cycles", s, p, n); end
  endtask

  task automatic test_reset;
    logic [AW-1:0] addrs [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    total += 2;
    if (seg_out !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", seg_out); end
    if (dig_sel !== 4'hF) begin bad++; $display("FAIL reset_sel: got %h want f", dig_sel); end
    @(negedge clk);
    total += 2;
    if (seg_out !== 8'hFF) begin bad++; $display("FAIL first_dead_seg: got %h want ff", seg_out); end
    if (dig_sel !== 4'hF) begin bad++; $display("FAIL first_dead_sel: got %h want f", dig_sel); end
    foreach (addrs[i]) begin
      @(negedge clk); address = addrs[i]; #1;
      total++;
      if (readdata !== ((addrs[i] == 4'd15) ? 32'h1 : 32'hFF))
        begin bad++; $display("FAIL reset_read a=%0d: got %h want %h", addrs[i], readdata, (addrs[i] == 4'd15) ? 32'h1 : 32'hFF); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); address = AW'($urandom_range(4, 14)); #1;
      total++;
      if (readdata !== 32'h0) begin bad++; $display("FAIL unused_read a=%0d: got %h want 0", address, readdata); end
    end
    @(negedge clk);
  endtask

  task automatic test_scan_order;
    logic [31:0] pats [4] = '{32'hC0, 32'hF9, 32'hA4, 32'hB0};
    int lit;
    for (int round = 0; round < 2; round++) begin
      for (int d = 0; d < ND; d++) wr(AW'(d), (round == 0) ? pats[d] : $urandom);
      lit = 0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        total += 2;
        if (seg_out !== exp_seg) begin bad++; $display("FAIL scan_seg c=%0d: got %h want %h", c, seg_out, exp_seg); end
        if (dig_sel !== exp_sel) begin bad++; $display("FAIL scan_sel c=%0d: got %h want %h", c, dig_sel, exp_sel); end
        if (c >= 8 && dig_sel !== 4'hF) lit++;
      end
      total++;
      if (lit != 12) begin bad++; $display("FAIL scan_lit_count: got %0d want 12", lit); end
    end
  endtask

  task automatic test_blank;
    int lit = 0;
    wr(4'hF, 32'h0000_0401);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      total += 2;
      if (seg_out !== exp_seg) begin bad++; $display("FAIL blank_seg c=%0d: got %h want %h", c, seg_out, exp_seg); end
      if (dig_sel !== exp_sel) begin bad++; $display("FAIL blank_sel c=%0d: got %h want %h", c, dig_sel, exp_sel); end
      if (c >= 8 && dig_sel !== 4'hF) lit++;
    end
    total++;
    if (lit != 9) begin bad++; $display("FAIL blank_lit_count: got %0d want 9", lit); end
    for (int k = 0; k < 3; k++) begin
      wr(4'hF, {$urandom_range(0, 1048575), 4'($urandom), 7'($urandom), 1'b1});
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        total += 2;
        if (seg_out !== exp_seg) begin bad++; $display("FAIL rblank_seg: got %h want %h", seg_out, exp_seg); end
        if (dig_sel !== exp_sel) begin bad++; $display("FAIL rblank_sel: got %h want %h", dig_sel, exp_sel); end
      end
    end
    wr(4'hF, 32'h1);
    @(negedge clk);
  endtask

  task automatic test_disable;
    wait_slot(2, 1);
    wr(4'hF, 32'h0);
    total += 2;
    if (dig_sel !== 4'hB) begin bad++; $display("FAIL dis_edge0_sel: got %h want b", dig_sel); end
    if (seg_out !== exp_seg) begin bad++; $display("FAIL dis_edge0_seg: got %h want %h", seg_out, exp_seg); end
    @(negedge clk);
    total++;
    if (dig_sel !== 4'hB) begin bad++; $display("FAIL dis_edge1_sel: got %h want b", dig_sel); end
    @(negedge clk);
    total += 2;
    if (dig_sel !== 4'hF) begin bad++; $display("FAIL dis_edge2_sel: got %h want f", dig_sel); end
    if (seg_out !== 8'hFF) begin bad++; $display("FAIL dis_edge2_seg: got %h want ff", seg_out); end
    wr(4'd3, $urandom);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      address = AW'($urandom_range(0, 15)); #1;
      total += 3;
      if (seg_out !== 8'hFF || seg_out !== exp_seg) begin bad++; $display("FAIL off_seg: got %h want ff", seg_out); end
      if (dig_sel !== 4'hF || dig_sel !== exp_sel) begin bad++; $display("FAIL off_sel: got %h want f", dig_sel); end
      if (readdata !== exp_read(address)) begin bad++; $display("FAIL off_read a=%0d: got %h want %h", address, readdata, exp_read(address)); end
    end
    @(negedge clk);
    wr(4'hF, 32'h1);
    for (int c = 0; c < 2; c++) begin
      total++;
      if (dig_sel !== 4'hF) begin bad++; $display("FAIL reen_dead c=%0d: got %h want f", c, dig_sel); end
      @(negedge clk);
    end
    total += 2;
    if (dig_sel !== 4'hE) begin bad++; $display("FAIL reen_first_sel: got %h want e", dig_sel); end
    if (seg_out !== m_dig[0]) begin bad++; $display("FAIL reen_first_seg: got %h want %h", seg_out, m_dig[0]); end
  endtask

  task automatic test_live_update;
    wr(4'd1, 32'hF9);
    wait_slot(1, 1);
    wr(4'd1, 32'h92);
    total++;
    if (seg_out !== 8'hF9) begin bad++; $display("FAIL live_edge1: got %h want f9", seg_out); end
    @(negedge clk);
    total += 2;
    if (seg_out !== 8'h92) begin bad++; $display("FAIL live_edge2_seg: got %h want 92", seg_out); end
    if (dig_sel !== 4'hD) begin bad++; $display("FAIL live_edge2_sel: got %h want d", dig_sel); end
    #2 reset_n = 1'b0;
    #1;
    address = 4'd1; #0.5;
    total += 3;
    if (seg_out !== 8'hFF) begin bad++; $display("FAIL async_rst_seg: got %h want ff", seg_out); end
    if (dig_sel !== 4'hF) begin bad++; $display("FAIL async_rst_sel: got %h want f", dig_sel); end
    if (readdata !== 32'hFF) begin bad++; $display("FAIL async_rst_read: got %h want ff", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hex;
    logic [31:0] w;
    wr(4'd0, 32'h0000_0108);
    address = 4'd0; #1;
    total++;
`ifdef PIO_SEG_SCAN_HEX_DECODE_EN
    if (readdata !== 32'h00) begin bad++; $display("FAIL hex_108: got %h want 00", readdata); end
`else
    if (readdata !== 32'h08) begin bad++; $display("FAIL hex_108: got %h want 08", readdata); end
`endif
    @(negedge clk);
    wr(4'd0, 32'h0000_018F);
    address = 4'd0; #1;
    total++;
`ifdef PIO_SEG_SCAN_HEX_DECODE_EN
    if (readdata !== 32'h8E) begin bad++; $display("FAIL hex_18f: got %h want 8e", readdata); end
`else
    if (readdata !== 32'h8F) begin bad++; $display("FAIL hex_18f: got %h want 8f", readdata); end
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w = $urandom | 32'h100;
      wr(AW'(k % ND), w);
      address = AW'(k % ND); #1;
      total++;
      if (readdata !== exp_read(address)) begin bad++; $display("FAIL hex_rand w=%h: got %h want %h", w, readdata, exp_read(address)); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int r;
    wait_slot(1, 3);
    wr(4'hF, 32'h0000_0401);
    for (int c = 0; c < 300; c++) begin
      total += 2;
      if (seg_out !== exp_seg) begin bad++; $display("FAIL b2b_seg c=%0d: got %h want %h", c, seg_out, exp_seg); end
      if (dig_sel !== exp_sel) begin bad++; $display("FAIL b2b_sel c=%0d: got %h want %h", c, dig_sel, exp_sel); end
      r = $urandom_range(0, 99);
      if (r < 25) wr(AW'($urandom_range(0, ND - 1)), $urandom);
      else if (r < 35) wr(4'hF, ($urandom & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 3) != 0)));
      else if (r < 45) wr(AW'($urandom_range(4, 14)), $urandom);
      else begin
        address = AW'($urandom_range(0, 15)); #1;
        total++;
        if (readdata !== exp_read(address)) begin bad++; $display("FAIL b2b_read a=%0d: got %h want %h", address, readdata, exp_read(address)); end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_scan_order;
    test_blank;
    test_disable;
    test_live_update;
    test_hex;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
